serial_paralelo_tx: RTL and testbench

Serial-to-parallel deserializer for the transmit-side PHY. Receives the bit stream produced by the receive-side parallel-to-serial block: idle symbols 0xBC (COM) while inactive, data bytes once the link is up. It hunts for COM byte alignment and asserts `active` after four consecutive aligned COMs. It then delivers each aligned byte on `data_out`, flagging non-COM bytes with `valid_out`.

---
 rtl/phy_pkg.sv | 14 +
 rtl/com_detector.sv | 12 +
 rtl/serial_paralelo_tx.sv | 158 +++++++++++++++
 tb/tb_serial_paralelo_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: constants and types shared by the PHY serial blocks.
//   COM_SYM  - idle / alignment symbol (K28.5-style 0xBC)
//   BYTE_W   - byte width
//   state_e  - alignment FSM states
package phy_pkg;
    localparam int         BYTE_W  = 8;
    localparam logic [7:0] COM_SYM = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_e;
endpackage

// File: rtl/com_detector.sv
// com_detector: combinational match of a byte against the COM symbol.
// Ports:
//   byte_in  in  8  candidate byte
//   is_com   out 1  byte_in == COM_SYM
module com_detector
    import phy_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    output logic              is_com
);
    assign is_com = (byte_in == COM_SYM);
endmodule

// File: rtl/serial_paralelo_tx.sv
// serial_paralelo_tx: serial-to-parallel deserializer with COM alignment.
// Hunts for a COM byte on every bit, then counts BC_LOCK consecutive aligned
// COMs before declaring the link active and delivering bytes.
// Optional feature macro: LOCK_LOSS_EN (drop lock after LOSS_BYTES zero bytes).
// Ports:
//   clk        in  1  serial bit clock
//   reset_L    in  1  async active-low reset
//   serial_in  in  1  serial data, MSB first
//   data_out   out 8  last completed aligned byte
//   valid_out  out 1  one-clk pulse for a new non-COM byte while active
//   active     out 1  link up
module serial_paralelo_tx
    import phy_pkg::*;
#(
    parameter int BC_LOCK    = 4,
    parameter int LOSS_BYTES = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);
    localparam logic [3:0] BC_LOCK_W = 4'(BC_LOCK);

    // Elaboration-time range checks on the configuration.
    if (BC_LOCK < 2 || BC_LOCK > 15) begin : g_bad_bc_lock
        $error("BC_LOCK out of range 2..15");
    end
    if (LOSS_BYTES < 1 || LOSS_BYTES > 15) begin : g_bad_loss
        $error("LOSS_BYTES out of range 1..15");
    end

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        bc_cnt_q, bc_cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              active_q, active_d;
    logic [BYTE_W-1:0] nxt;
    logic              is_com;
    logic              byte_done;

`ifdef LOCK_LOSS_EN
    localparam logic [3:0] LOSS_W = 4'(LOSS_BYTES);
    logic [3:0] zero_cnt_q, zero_cnt_d;
`endif

    assign nxt       = {sr_q[BYTE_W-2:0], serial_in};
    assign byte_done = (bit_cnt_q == 3'd7);

    com_detector u_com_det (
        .byte_in (nxt),
        .is_com  (is_com)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = nxt;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        active_d  = active_q;
`ifdef LOCK_LOSS_EN
        zero_cnt_d = zero_cnt_q;
`endif
        case (state_q)
            HUNT: begin
                // Bit phase is undefined while hunting; a COM match pins it.
                bit_cnt_d = 3'd0;
                bc_cnt_d  = 4'd0;
                if (is_com) begin
                    state_d  = COUNT;
                    bc_cnt_d = 4'd1;
                end
            end
            COUNT: begin
                if (byte_done) begin
                    data_d = nxt;
                    if (is_com) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (bc_cnt_q + 4'd1 == BC_LOCK_W) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Failing edge does not itself search for COM.
                        state_d   = HUNT;
                        bc_cnt_d  = 4'd0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    data_d  = nxt;
                    valid_d = !is_com;
`ifdef LOCK_LOSS_EN
                    if (nxt == '0) begin
                        if (zero_cnt_q + 4'd1 == LOSS_W) begin
                            state_d    = HUNT;
                            active_d   = 1'b0;
                            valid_d    = 1'b0;
                            bc_cnt_d   = 4'd0;
                            bit_cnt_d  = 3'd0;
                            zero_cnt_d = 4'd0;
                        end else begin
                            zero_cnt_d = zero_cnt_q + 4'd1;
                        end
                    end else begin
                        zero_cnt_d = 4'd0;
                    end
`endif
                end
            end
            default: begin
                state_d   = HUNT;
                active_d  = 1'b0;
                bc_cnt_d  = 4'd0;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

`ifdef LOCK_LOSS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) zero_cnt_q <= '0;
        else          zero_cnt_q <= zero_cnt_d;
    end
`endif

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
endmodule

// File: tb/tb_serial_paralelo_tx.sv
module tb_serial_paralelo_tx;
    logic       clk = 1'b0;
    logic       reset_L;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    serial_paralelo_tx dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    // Count valid pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) vcnt++;
    end

    // Inputs change on the falling edge; each call returns at the next falling edge.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_lock();
        repeat (4) send_byte(8'hBC);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (3) begin
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        reset_L   = 1'b1;
        serial_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        repeat (3) begin
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        reset_L   = 1'b1;
        serial_in = 1'b0;
    endtask

    task automatic test_lock_data();
        int v0;
        do_reset();
        v0 = vcnt;
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL lock_early: active got %b want 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL lock_active: got %b want 1", active); end
        checks++; if (data_out !== 8'hBC) begin errors++; $display("FAIL lock_data: got %h want bc", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lock_valid: got %b want 0", valid_out); end
        send_byte(8'h55);
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL data55: got %h want 55", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL valid55: got %b want 1", valid_out); end
        send_bit(1'b1);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL valid_width: got %b want 0", valid_out); end
        for (int i = 6; i >= 0; i--) send_bit(1'(8'hA3 >> i));
        checks++; if (data_out !== 8'hA3) begin errors++; $display("FAIL dataA3: got %h want a3", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL validA3: got %b want 1", valid_out); end
        checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL lock_pulses: got %0d want 2", vcnt - v0); end
    endtask

    task automatic test_misaligned();
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL mis_early: active got %b want 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mis_active: got %b want 1", active); end
        send_byte(8'h0F);
        checks++; if (data_out !== 8'h0F) begin errors++; $display("FAIL mis_data: got %h want 0f", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b want 1", valid_out); end
    endtask

    task automatic test_broken_preamble();
        int v0;
        do_reset();
        v0 = vcnt;
        repeat (3) send_byte(8'hBC);
        send_byte(8'h12);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL brk_after12: active got %b want 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL brk_bc1: active got %b want 0", active); end
        send_byte(8'hBC);
        send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL brk_bc3: active got %b want 0", active); end
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL brk_novalid: pulses got %0d want 0", vcnt - v0); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL brk_relock: active got %b want 1", active); end
    endtask

    task automatic test_idle_active();
        do_reset();
        send_lock();
        send_byte(8'h11);
        checks++; if (data_out !== 8'h11 || valid_out !== 1'b1) begin errors++; $display("FAIL idle_d11: got %h/%b want 11/1", data_out, valid_out); end
        send_byte(8'hBC);
        checks++; if (data_out !== 8'hBC) begin errors++; $display("FAIL idle_data: got %h want bc", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", valid_out); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL idle_active: got %b want 1", active); end
        send_byte(8'h22);
        checks++; if (data_out !== 8'h22 || valid_out !== 1'b1) begin errors++; $display("FAIL idle_d22: got %h/%b want 22/1", data_out, valid_out); end
    endtask

    task automatic test_reset_mid_active();
        do_reset();
        send_lock();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_active: got %b want 0", active); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid_out); end
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) send_byte(8'hBC);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_relock_early: active got %b want 0", active); end
        send_byte(8'hBC);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_relock: active got %b want 1", active); end
    endtask

    task automatic test_zero_bytes();
        do_reset();
        send_lock();
        repeat (7) send_byte(8'h00);
        checks++; if (active !== 1'b1 || valid_out !== 1'b1) begin errors++; $display("FAIL zero7: active/valid got %b/%b want 1/1", active, valid_out); end
        send_byte(8'h00);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL zero8_data: got %h want 00", data_out); end
`ifdef LOCK_LOSS_EN
        checks++; if (active !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL zero8_loss: active/valid got %b/%b want 0/0", active, valid_out); end
`else
        checks++; if (active !== 1'b1 || valid_out !== 1'b1) begin errors++; $display("FAIL zero8_keep: active/valid got %b/%b want 1/1", active, valid_out); end
`endif
    endtask

    task automatic test_zero_recover();
        do_reset();
        send_lock();
        repeat (7) send_byte(8'h00);
        send_byte(8'h01);
        checks++; if (active !== 1'b1 || data_out !== 8'h01 || valid_out !== 1'b1) begin errors++; $display("FAIL zero_rec: a/d/v got %b/%h/%b want 1/01/1", active, data_out, valid_out); end
        repeat (7) send_byte(8'h00);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL zero_rec7: active got %b want 1", active); end
    endtask

    initial begin
        reset_L   = 1'b0;
        serial_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock_data();
        test_misaligned();
        test_broken_preamble();
        test_idle_active();
        test_reset_mid_active();
        test_zero_bytes();
        test_zero_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
